neuron_output_packer: RTL and testbench

- Receiving end of the neuron activation path: consumes the 1-bit neuron decisions produced by the activation comparators, one per accepted cycle.
- Packs the bits LSB-first into WIDTH-bit words and buffers them in a small FIFO.
- Returns the words to the host over a valid/ready read bus, with a per-layer flush and last marker.

---
 rtl/neuron_pkg.sv | 14 +
 rtl/output_word_fifo.sv | 56 +++++
 rtl/neuron_output_packer.sv | 100 ++++++++++
 tb/tb_neuron_output_packer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types for the neuron activation output path: one packed FIFO entry
// carrying up to NEURON_WIDTH decision bits plus its valid-bit count and layer marker.
package neuron_pkg;

    localparam int NEURON_WIDTH = 22;
    localparam int NBITS_W      = $clog2(NEURON_WIDTH + 1);

    typedef struct packed {
        logic                    last;
        logic [NBITS_W-1:0]      nbits;
        logic [NEURON_WIDTH-1:0] data;
    } out_word_t;

endpackage

// File: rtl/output_word_fifo.sv
// Synchronous DEPTH-entry FIFO of packed output words; the head entry is shown
// combinationally and reads as all zeros while the FIFO is empty.
module output_word_fifo
    import neuron_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  out_word_t                  push_word,
    input  logic                       pop,
    output out_word_t                  head_word,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    out_word_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

    assign head_word = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/neuron_output_packer.sv
// Packs accepted neuron decision bits LSB-first into WIDTH-bit words, buffers
// them in a small FIFO and returns them over a valid/ready read bus.
module neuron_output_packer
    import neuron_pkg::*;
#(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_valid,
    input  logic                       bit_data,
    input  logic                       layer_done,
    output logic                       bit_ready,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(WIDTH+1)-1:0] rd_nbits,
    output logic                       rd_last
);

    // Handshakes: a bit / layer_done is taken on a cycle where it is asserted
    // together with bit_ready; a word is popped where rd_valid & rd_ready.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int FCW   = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] shadow;
    logic [CNT_W-1:0] bit_cnt;

    logic             bit_acc;
    logic             ld_acc;
    logic             fill;
    logic             commit;
    logic [WIDTH-1:0] shadow_next;
    logic [CNT_W-1:0] cnt_next;
    out_word_t        push_word;
    out_word_t        head_word;

    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;

    // No pass-through: a pop while full only frees space on the next cycle.
    assign bit_ready = (fifo_count != FCW'(DEPTH));
    assign bit_acc   = bit_valid && bit_ready;
    assign ld_acc    = layer_done && bit_ready;

    always_comb begin
        shadow_next = shadow;
        cnt_next    = bit_cnt;
        fill        = 1'b0;
        if (bit_acc) begin
            shadow_next = shadow | ({{(WIDTH-1){1'b0}}, bit_data} << bit_cnt);
            cnt_next    = bit_cnt + 1'b1;
            fill        = (bit_cnt == CNT_W'(WIDTH - 1));
        end
        // A layer_done with nothing pending writes nothing.
        commit          = fill || (ld_acc && (cnt_next != '0));
        push_word       = '0;
        push_word.last  = ld_acc;
        push_word.nbits = cnt_next;
        push_word.data  = shadow_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            bit_cnt <= '0;
        end else if (commit) begin
            shadow  <= '0;
            bit_cnt <= '0;
        end else if (bit_acc) begin
            shadow  <= shadow_next;
            bit_cnt <= cnt_next;
        end
    end

    assign fifo_push = commit && !fifo_full;

    output_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_word (push_word),
        .pop       (rd_ready),
        .head_word (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rd_valid = !fifo_empty;
    assign rd_data  = head_word.data;
    assign rd_nbits = head_word.nbits;
    assign rd_last  = head_word.last;

endmodule

// File: tb/tb_neuron_output_packer.sv
// Bench for neuron_output_packer: table of single-word packets plus hand
// sequences for latency, full FIFO, empty flush, reset and push/pop overlap.
module tb_neuron_output_packer;

    localparam int W  = 22;
    localparam int D  = 4;
    localparam int NW = $clog2(W + 1);
    localparam logic [W-1:0] MASK = {W{1'b1}};

    typedef logic [W+NW:0] exp_t;  // {last, nbits, data}

    typedef struct {
        logic [W-1:0] bits;
        int           n;
        logic         ld;
        logic         ld_sep;
        logic [W-1:0] e_data;
        int           e_nbits;
        logic         e_last;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bit_valid = 1'b0;
    logic          bit_data = 1'b0;
    logic          layer_done = 1'b0;
    logic          bit_ready;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [W-1:0]  rd_data;
    logic [NW-1:0] rd_nbits;
    logic          rd_last;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   rand_rdy = 1'b0;
    vec_t vecs[7];

    neuron_output_packer #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .layer_done (layer_done),
        .bit_ready  (bit_ready),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_nbits   (rd_nbits),
        .rd_last    (rd_last)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic last, input int nb, input logic [W-1:0] d);
        logic [NW-1:0] nbv;
        nbv = NW'(nb);
        return {last, nbv, d};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%0h with no word expected", {rd_last, rd_nbits, rd_data});
            end else begin
                mon_e = exp_q.pop_front();
                check("rd_word", 32'({rd_last, rd_nbits, rd_data}), 32'(mon_e));
            end
        end
    end

    // ---------------- drivers ----------------
    // Called just after a posedge; returns just after the accepting posedge.
    task automatic drive(input logic b, input logic v, input logic ld);
        int waited;
        waited = 0;
        bit_valid  = v;
        bit_data   = b;
        layer_done = ld;
        if (rand_rdy) rd_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        while (!bit_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bit_ready) check("bit_ready_timeout", 32'(bit_ready), 32'd1);
        @(posedge clk);
        #1;
        bit_valid  = 1'b0;
        layer_done = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] bits, input int n, input logic ld_last);
        for (int i = 0; i < n; i++) drive(bits[i], 1'b1, ld_last && (i == n - 1));
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        rd_ready = 1'b1;
        @(negedge clk);
        while (!(exp_q.size() == 0 && !rd_valid) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_rd_valid", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] pat;
        logic [W-1:0] w [4];
        logic [W-1:0] a;
        logic [W-1:0] b;

        vecs[0] = '{22'h155555, 22, 1'b0, 1'b0, 22'h155555, 22, 1'b0};
        vecs[1] = '{22'h00003B,  6, 1'b1, 1'b0, 22'h00003B,  6, 1'b1};
        vecs[2] = '{22'h3FFFFF, 22, 1'b1, 1'b0, 22'h3FFFFF, 22, 1'b1};
        vecs[3] = '{22'h000000,  1, 1'b1, 1'b0, 22'h000000,  1, 1'b1};
        vecs[4] = '{22'h2AAAAA, 22, 1'b0, 1'b0, 22'h2AAAAA, 22, 1'b0};
        vecs[5] = '{22'h000004,  3, 1'b1, 1'b0, 22'h000004,  3, 1'b1};
        vecs[6] = '{22'h00001F,  5, 1'b0, 1'b1, 22'h00001F,  5, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_bit_ready", 32'(bit_ready), 32'd1);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_rd_nbits", 32'(rd_nbits), 32'd0);
        check("reset_rd_last", 32'(rd_last), 32'd0);

        // Full word latency: rd_valid one cycle after the 22nd bit
        rd_ready = 1'b1;
        pat = 22'h155555;
        exp_q.push_back(mk(1'b0, 22, pat));
        for (int i = 0; i < 21; i++) drive(pat[i], 1'b1, 1'b0);
        check("no_early_valid", 32'(rd_valid), 32'd0);
        drive(pat[21], 1'b1, 1'b0);
        check("latency_rd_valid", 32'(rd_valid), 32'd1);
        check("latency_rd_data", 32'(rd_data), 32'h155555);
        @(posedge clk);
        #1;
        check("valid_pulse_ends", 32'(rd_valid), 32'd0);

        // Table of single-word packets with random read backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back(mk(vecs[k].e_last, vecs[k].e_nbits, vecs[k].e_data));
            send_word(vecs[k].bits, vecs[k].n, vecs[k].ld);
            if (vecs[k].ld_sep) drive(1'b0, 1'b0, 1'b1);
            drain();
        end
        rand_rdy = 1'b0;

        // Empty flush writes nothing and leaves the counter at zero
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("empty_flush_no_word", 32'(rd_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(mk(1'b1, 3, 22'h000005));
        send_word(22'h000005, 3, 1'b1);
        drain();

        // Fill the FIFO: 88 bits with no reads, 89th bit held
        rd_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w[k] = W'($urandom) & MASK;
            exp_q.push_back(mk(1'b0, 22, w[k]));
            send_word(w[k], 22, 1'b0);
        end
        check("full_bit_ready", 32'(bit_ready), 32'd0);
        check("full_head", 32'(rd_data), 32'(w[0]));
        bit_valid = 1'b1;
        bit_data  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held_bit_ready", 32'(bit_ready), 32'd0);
            check("head_stable", 32'(rd_data), 32'(w[0]));
        end
        @(posedge clk);
        #1 rd_ready = 1'b1;
        @(negedge clk);
        check("no_passthrough", 32'(bit_ready), 32'd0);
        @(posedge clk);
        #1 rd_ready = 1'b0;
        check("ready_after_pop", 32'(bit_ready), 32'd1);
        @(posedge clk);
        #1 bit_valid = 1'b0;
        exp_q.push_back(mk(1'b1, 1, 22'h000001));
        drive(1'b0, 1'b0, 1'b1);
        drain();

        // Reset mid-word with a buffered word discards everything
        rd_ready = 1'b0;
        a = W'($urandom) & MASK;
        b = W'($urandom) & MASK;
        send_word(a, 22, 1'b0);
        send_word(b, 10, 1'b0);
        check("pre_reset_valid", 32'(rd_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("post_reset_rd_valid", 32'(rd_valid), 32'd0);
        check("post_reset_bit_ready", 32'(bit_ready), 32'd1);
        check("post_reset_rd_data", 32'(rd_data), 32'd0);
        check("post_reset_rd_nbits", 32'(rd_nbits), 32'd0);
        exp_q.push_back(mk(1'b0, 22, 22'h3FFFFF));
        rd_ready = 1'b1;
        send_word(22'h3FFFFF, 22, 1'b0);
        drain();

        // Pop and commit on the same edge with one word buffered
        rd_ready = 1'b0;
        a = W'($urandom) & MASK;
        b = W'($urandom) & MASK;
        exp_q.push_back(mk(1'b0, 22, a));
        exp_q.push_back(mk(1'b0, 22, b));
        send_word(a, 22, 1'b0);
        for (int i = 0; i < 21; i++) drive(b[i], 1'b1, 1'b0);
        check("one_word_buffered", 32'(rd_valid), 32'd1);
        rd_ready = 1'b1;
        drive(b[21], 1'b1, 1'b0);
        rd_ready = 1'b0;
        check("overlap_new_head_valid", 32'(rd_valid), 32'd1);
        check("overlap_new_head_data", 32'(rd_data), 32'(b));
        @(posedge clk);
        #1 rd_ready = 1'b1;
        @(posedge clk);
        #1 rd_ready = 1'b0;
        check("overlap_count_was_one", 32'(rd_valid), 32'd0);
        check("overlap_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
